// File: rtl/data_packet_assembler.sv
// Reassembles DATA_SIZE stream chunks into one packet tagged with address and 8-bit additive checksum.
// Packet valid 1 cycle after last chunk; holds until pkt_ready_i, stream stalls meanwhile; idle timeout to ERROR.
module data_packet_assembler #(
    parameter int DATA_WIDTH     = 8,
    parameter int DATA_SIZE      = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                            clk_i,
    input  logic                            resetn_i,
    input  logic                            start_i,
    input  logic [15:0]                     dst_address_i,
    input  logic                            byte_valid_i,
    input  logic [DATA_WIDTH-1:0]           byte_i,
    output logic                            byte_ready_o,
    output logic                            pkt_valid_o,
    input  logic                            pkt_ready_i,
    output logic [DATA_SIZE*DATA_WIDTH-1:0] pkt_data_o,
    output logic [15:0]                     pkt_addr_o,
    output logic [7:0]                      pkt_checksum_o,
    output logic                            busy_o,
    output logic                            error_o
);

    localparam int PW      = DATA_SIZE * DATA_WIDTH;
    localparam int CW      = $clog2(DATA_SIZE) + 1;
    localparam int TW      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_HOLD    = 2'd2,
        ST_ERROR   = 2'd3
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [CW-1:0]   cnt_q;
    logic [TW-1:0]   idle_q;
    logic [7:0]      acc_q;
    logic [PW-1:0]   data_q;
    logic [15:0]     addr_q;
    logic [7:0]      csum_q;

    logic            start_acc;
    logic            byte_acc;
    logic            last_byte;
    logic            timeout_fire;
    logic [7:0]      byte8;
    logic [7:0]      acc_next;

    always_comb begin
        start_acc    = start_i && ((state_q == ST_IDLE) || (state_q == ST_ERROR));
        byte_acc     = byte_valid_i && byte_ready_o;
        last_byte    = byte_acc && (cnt_q == CW'(DATA_SIZE - 1));
        // An accept in the firing cycle wins over the timeout.
        timeout_fire = (TIMEOUT_CYCLES > 0) && (state_q == ST_COLLECT) && !byte_acc
                       && (idle_q == TW'(TO_LAST));
        byte8        = 8'(byte_i);
        acc_next     = acc_q + byte8;
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_acc) state_d = ST_COLLECT;
            end
            ST_COLLECT: begin
                if (last_byte)         state_d = ST_HOLD;
                else if (timeout_fire) state_d = ST_ERROR;
            end
            ST_HOLD: begin
                if (pkt_ready_i) state_d = ST_IDLE;
            end
            ST_ERROR: begin
                if (start_acc) state_d = ST_COLLECT;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        byte_ready_o = (state_q == ST_COLLECT);
        pkt_valid_o  = (state_q == ST_HOLD);
        busy_o       = (state_q == ST_COLLECT) || (state_q == ST_HOLD);
        error_o      = (state_q == ST_ERROR);
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            cnt_q  <= '0;
            idle_q <= '0;
            acc_q  <= '0;
            data_q <= '0;
            addr_q <= '0;
            csum_q <= '0;
        end else if (start_acc) begin
            cnt_q  <= '0;
            idle_q <= '0;
            acc_q  <= '0;
            data_q <= '0;
            addr_q <= dst_address_i;
            csum_q <= '0;
        end else if (state_q == ST_COLLECT) begin
            if (byte_acc) begin
                for (int k = 0; k < DATA_SIZE; k++) begin
                    if (cnt_q == CW'(k)) data_q[k*DATA_WIDTH +: DATA_WIDTH] <= byte_i;
                end
                cnt_q  <= cnt_q + CW'(1);
                acc_q  <= acc_next;
                idle_q <= '0;
                if (last_byte) csum_q <= acc_next;
            end else if (timeout_fire) begin
                // Partial packet is dropped on timeout.
                cnt_q  <= '0;
                acc_q  <= '0;
                data_q <= '0;
                idle_q <= '0;
            end else begin
                idle_q <= idle_q + TW'(1);
            end
        end
    end

    assign pkt_data_o     = data_q;
    assign pkt_addr_o     = addr_q;
    assign pkt_checksum_o = csum_q;

endmodule

// File: tb/tb_data_packet_assembler.sv
// Directed + randomized bench for data_packet_assembler against a queue-based packet model.
module tb_data_packet_assembler;

    logic         clk_i = 1'b0;
    logic         resetn_i;
    logic         start_i;
    logic [15:0]  dst_address_i;
    logic         byte_valid_i;
    logic [7:0]   byte_i;
    logic         byte_ready_o;
    logic         pkt_valid_o;
    logic         pkt_ready_i;
    logic [255:0] pkt_data_o;
    logic [15:0]  pkt_addr_o;
    logic [7:0]   pkt_checksum_o;
    logic         busy_o;
    logic         error_o;

    data_packet_assembler #(.DATA_WIDTH(8), .DATA_SIZE(32), .TIMEOUT_CYCLES(64)) dut (
        .clk_i(clk_i), .resetn_i(resetn_i), .start_i(start_i), .dst_address_i(dst_address_i),
        .byte_valid_i(byte_valid_i), .byte_i(byte_i), .byte_ready_o(byte_ready_o),
        .pkt_valid_o(pkt_valid_o), .pkt_ready_i(pkt_ready_i), .pkt_data_o(pkt_data_o),
        .pkt_addr_o(pkt_addr_o), .pkt_checksum_o(pkt_checksum_o), .busy_o(busy_o), .error_o(error_o)
    );

    always #5 clk_i = ~clk_i;

    int           n_checks = 0;
    int           n_fail   = 0;
    logic [7:0]   exp_q[$];
    logic [15:0]  exp_addr;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] model_data();
        logic [255:0] r = '0;
        for (int k = 0; k < exp_q.size(); k++) r[k*8 +: 8] = exp_q[k];
        return r;
    endfunction

    function automatic logic [7:0] model_sum();
        int s = 0;
        foreach (exp_q[i]) s += int'(exp_q[i]);
        return 8'(s % 256);
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_start(input logic [15:0] addr);
        start_i       = 1'b1;
        dst_address_i = addr;
        tick();
        start_i       = 1'b0;
        exp_q.delete();
        exp_addr      = addr;
        chk("start_busy", busy_o, 1'b1);
        chk("start_data_clear", pkt_data_o, '0);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        byte_valid_i = 1'b0;
        repeat (gap) tick();
        byte_valid_i = 1'b1;
        byte_i       = b;
        chk("byte_ready", byte_ready_o, 1'b1);
        tick();
        byte_valid_i = 1'b0;
        exp_q.push_back(b);
    endtask

    task automatic check_pkt(input string tag);
        chk({tag, "_valid"}, pkt_valid_o, 1'b1);
        chk({tag, "_data"}, pkt_data_o, model_data());
        chk({tag, "_addr"}, pkt_addr_o, exp_addr);
        chk({tag, "_csum"}, pkt_checksum_o, model_sum());
        chk({tag, "_err"}, error_o, 1'b0);
        chk({tag, "_ready_low"}, byte_ready_o, 1'b0);
    endtask

    task automatic drain_pkt(input string tag);
        pkt_ready_i = 1'b1;
        tick();
        pkt_ready_i = 1'b0;
        chk({tag, "_idle_valid"}, pkt_valid_o, 1'b0);
        chk({tag, "_idle_busy"}, busy_o, 1'b0);
        chk({tag, "_retain_data"}, pkt_data_o, model_data());
    endtask

    initial begin
        resetn_i = 1'b0; start_i = 1'b0; dst_address_i = '0; byte_valid_i = 1'b0;
        byte_i = '0; pkt_ready_i = 1'b0; exp_addr = '0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_valid", pkt_valid_o, 1'b0);
        chk("rst_data", pkt_data_o, '0);
        chk("rst_addr", pkt_addr_o, '0);
        chk("rst_csum", pkt_checksum_o, '0);
        chk("rst_busy_err_rdy", {busy_o, error_o, byte_ready_o}, 3'b000);
        resetn_i = 1'b1;
        tick();

        // Normal packet 0x00..0x1F, then backpressure in HOLD
        do_start(16'h1234);
        for (int k = 0; k < 31; k++) send_byte(8'(k), 0);
        chk("t1_not_yet_valid", pkt_valid_o, 1'b0);
        send_byte(8'h1F, 0);
        check_pkt("t1");
        chk("t1_csum_const", pkt_checksum_o, 8'hF0);
        byte_valid_i = 1'b1;
        byte_i       = 8'hAA;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("t2_hold_valid", pkt_valid_o, 1'b1);
            chk("t2_hold_data", pkt_data_o, model_data());
            chk("t2_hold_rdy", byte_ready_o, 1'b0);
        end
        byte_valid_i = 1'b0;
        drain_pkt("t2");

        // Gapped all-0xFF stream
        do_start(16'(($urandom)));
        for (int k = 0; k < 32; k++) send_byte(8'hFF, int'($urandom_range(0, 63)));
        check_pkt("t3");
        chk("t3_csum_const", pkt_checksum_o, 8'hE0);
        drain_pkt("t3");

        // Random data, random gaps, random backpressure
        for (int p = 0; p < 3; p++) begin
            do_start(16'($urandom));
            for (int k = 0; k < 32; k++) send_byte(8'($urandom), int'($urandom_range(0, 5)));
            repeat ($urandom_range(0, 8)) tick();
            check_pkt("rnd");
            drain_pkt("rnd");
        end

        // Timeout after 5 chunks
        do_start(16'hBEEF);
        for (int k = 0; k < 5; k++) send_byte(8'($urandom), 0);
        repeat (63) tick();
        chk("t4_pre_err", {error_o, busy_o}, 2'b01);
        tick();
        chk("t4_err", error_o, 1'b1);
        chk("t4_rdy", byte_ready_o, 1'b0);
        chk("t4_busy_valid", {busy_o, pkt_valid_o}, 2'b00);
        repeat (5) tick();
        chk("t4_sticky", error_o, 1'b1);
        do_start(16'h0F0F);
        chk("t4_err_clear", error_o, 1'b0);
        for (int k = 0; k < 32; k++) send_byte(8'($urandom), int'($urandom_range(0, 3)));
        check_pkt("t4_after");
        drain_pkt("t4_after");

        // Timeout before any chunk arrives
        do_start(16'h0001);
        repeat (64) tick();
        chk("t4b_err", error_o, 1'b1);

        // Chunk offered on the 64th idle cycle is accepted
        do_start(16'h5A5A);
        for (int k = 0; k < 3; k++) send_byte(8'($urandom), 0);
        send_byte(8'h77, 63);
        chk("t5_no_err", {error_o, busy_o}, 2'b01);
        for (int k = 4; k < 32; k++) send_byte(8'($urandom), 0);
        check_pkt("t5");
        drain_pkt("t5");

        // start_i mid-packet is ignored
        do_start(16'hCAFE);
        for (int k = 0; k < 10; k++) send_byte(8'($urandom), 0);
        start_i = 1'b1;
        dst_address_i = 16'hDEAD;
        send_byte(8'h3C, 0);
        start_i = 1'b0;
        for (int k = 11; k < 32; k++) send_byte(8'($urandom), 0);
        check_pkt("t6_start");
        drain_pkt("t6_start");

        // Reset mid-packet
        do_start(16'h7777);
        for (int k = 0; k < 16; k++) send_byte(8'($urandom), 0);
        resetn_i = 1'b0;
        #1;
        chk("t6_rst_data", pkt_data_o, '0);
        chk("t6_rst_addr", pkt_addr_o, '0);
        chk("t6_rst_ctl", {pkt_valid_o, busy_o, error_o, byte_ready_o, pkt_checksum_o}, 12'h000);
        tick();
        resetn_i = 1'b1;
        tick();
        do_start(16'h2468);
        for (int k = 0; k < 32; k++) send_byte(8'($urandom), int'($urandom_range(0, 2)));
        check_pkt("t6_fresh");
        drain_pkt("t6_fresh");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
